io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 Parameter NUM_SW, default 10: number of slide-switch inputs.
REQ-002 Parameter NUM_BTN, default 5: number of pushbutton inputs.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before accepting a change; legal range 2 or more.
REQ-004 Parameter BTN_ACTIVE_LOW, default 1: raw buttons read 0 when pressed.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 reset  input  1: asynchronous, active-high reset.
REQ-007 switches_raw  input  NUM_SW: asynchronous board switch pins.
REQ-008 buttons_raw  input  NUM_BTN: asynchronous board button pins.
REQ-009 evt_clear  input  1: one-cycle read-acknowledge strobe from the IO decoder.
REQ-010 evt_clear_mask  input  NUM_BTN: event bits to clear when evt_clear=1.
REQ-011 switches  output  NUM_SW: debounced switch levels, driving the IO block switch read at 12'hFFE.
REQ-012 pushButtons  output  NUM_BTN: debounced button levels, active-high (1 = pressed).
REQ-013 press_events  output  NUM_BTN: sticky per-button press flags.
REQ-014 event_any  output  1: OR-reduction of press_events.

Function
REQ-015 Each raw bit SHALL pass through a two-flop synchronizer; no other logic SHALL read raw pins.
REQ-016 Buttons SHALL be inverted after synchronization when BTN_ACTIVE_LOW=1, so all downstream logic is active-high.
REQ-017 Each bit SHALL hold a stable register and a counter of width clog2(DEBOUNCE_CYCLES).
REQ-018 While the synchronized value equals the stable value, the counter SHALL be 0.
REQ-019 While they differ, the counter SHALL increment each cycle.
REQ-020 On the cycle the counter equals DEBOUNCE_CYCLES-1 and values still differ, the stable register SHALL load the synchronized value and the counter SHALL return to 0.
REQ-021 Any return to equality before that point SHALL zero the counter, so glitches shorter than DEBOUNCE_CYCLES cycles never reach the outputs.
REQ-022 Latency: a raw change held steady SHALL appear on the output at the (DEBOUNCE_CYCLES+2)-th rising edge after the first edge that samples it.
REQ-023 A press event is a 0->1 transition of a debounced pushButtons bit; it SHALL set the matching press_events bit on the same edge that pushButtons rises.
REQ-024 press_events bits SHALL stay set until cleared by evt_clear with the matching mask bit = 1; mask bits = 0 SHALL leave their flags unchanged.
REQ-025 If a new press event and a clear of the same bit occur in the same cycle, the set SHALL win and the flag SHALL stay 1.
REQ-026 Releases (1->0 transitions) SHALL NOT create events; a held button SHALL produce exactly one event.
REQ-027 evt_clear while the mask is all zero SHALL have no effect.
REQ-028 event_any SHALL be combinational from the press_events register.

Reset
REQ-029 Reset SHALL force synchronizer flops to the released or low level: 0 after polarity correction, so 1 on the raw-side flops of active-low buttons.
REQ-030 Reset SHALL force all stable registers to 0, all counters to 0, press_events to 0, and event_any to 0.
REQ-031 Reset asserted mid-count SHALL abandon the pending change.
REQ-032 A button held through reset deassertion SHALL be debounced afresh and SHALL produce one event after DEBOUNCE_CYCLES+2 edges.

Structure
REQ-033 Shared package io_pkg SHALL hold NUM_SW, NUM_BTN, the IO address constants (12'hFFF LEDs, 12'hFFE switches, 12'hFFB-12'hFFD hex) and a new event-register address 12'hFFA.
REQ-034 Sub-module debounce_bit (synchronizer, stable register, counter; parameter DEBOUNCE_CYCLES) SHALL be instantiated NUM_SW+NUM_BTN times.
REQ-035 Event logic and the clear logic SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=8)
REQ-036 Switch 3 raw 0->1 held -> switches[3]=1 exactly at edge 10 after first sample; other bits stay 0.
REQ-037 Button 0 raw low pulse of 5 cycles -> pushButtons=0 and press_events=0 throughout.
REQ-038 Button 2 pressed 20 cycles then released -> press_events=5'b00100 and event_any=1 from the rise edge; the bit stays set after release.
REQ-039 evt_clear=1 with mask 5'b00100 on the same cycle button 2 debounces to pressed -> press_events[2] remains 1; the next clear -> 0.
REQ-040 Reset asserted at counter=5 during a switch change -> all outputs 0 immediately; after release, the change needs the full 10 edges again.
REQ-041 Two buttons bouncing alternately every 3 cycles for 30 cycles, then stable pressed -> exactly one event per button.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO-map constants for the memory-mapped IO block and its input conditioner.
package io_pkg;

    localparam int unsigned NUM_SW  = 10;
    localparam int unsigned NUM_BTN = 5;

    typedef logic [11:0] io_addr_t;

    localparam io_addr_t ADDR_LEDS     = 12'hFFF;
    localparam io_addr_t ADDR_SWITCHES = 12'hFFE;
    localparam io_addr_t ADDR_HEX_HI   = 12'hFFD;
    localparam io_addr_t ADDR_HEX_MID  = 12'hFFC;
    localparam io_addr_t ADDR_HEX_LO   = 12'hFFB;
    localparam io_addr_t ADDR_EVENTS   = 12'hFFA;

    function automatic logic is_hex_addr(input io_addr_t addr);
        return (addr >= ADDR_HEX_LO) && (addr <= ADDR_HEX_HI);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, optional polarity inversion, stable-count debouncer.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          sync_val;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Raw-side flops reset to the released level so the corrected value starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= INVERT;
            sync_q <= INVERT;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    assign sync_val = sync_q ^ INVERT;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_val != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync_val;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level = stable_q;
    // Look-ahead so the top can flag an event on the same edge the level rises.
    assign rise  = stable_d & ~stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces board switches and buttons and keeps sticky, software-clearable press flags.
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned NUM_SW          = io_pkg::NUM_SW,
    parameter int unsigned NUM_BTN         = io_pkg::NUM_BTN,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SW-1:0]  switches_raw,
    input  logic [NUM_BTN-1:0] buttons_raw,
    input  logic               evt_clear,
    input  logic [NUM_BTN-1:0] evt_clear_mask,
    output logic [NUM_SW-1:0]  switches,
    output logic [NUM_BTN-1:0] pushButtons,
    output logic [NUM_BTN-1:0] press_events,
    output logic               event_any
);

    logic [NUM_SW-1:0]  sw_rise_unused;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] clear_bits;
    logic [NUM_BTN-1:0] press_events_q, press_events_d;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (1'b0)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (switches_raw[i]),
            .level(switches[i]),
            .rise (sw_rise_unused[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .INVERT         (BTN_ACTIVE_LOW != 0)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (buttons_raw[i]),
            .level(pushButtons[i]),
            .rise (btn_rise[i])
        );
    end

    // A fresh press is ORed in after the clear so it survives a same-cycle acknowledge.
    always_comb begin
        clear_bits     = evt_clear ? evt_clear_mask : '0;
        press_events_d = (press_events_q & ~clear_bits) | btn_rise;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_events_q <= '0;
        end else begin
            press_events_q <= press_events_d;
        end
    end

    assign press_events = press_events_q;
    assign event_any    = |press_events_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench: window-based reference model feeds an expectation queue, monitor compares each cycle.
module tb_io_input_conditioner;

    localparam int unsigned NSW = 10;
    localparam int unsigned NBT = 5;
    localparam int unsigned DC  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [NSW-1:0] switches_raw;
    logic [NBT-1:0] buttons_raw;
    logic           evt_clear;
    logic [NBT-1:0] evt_clear_mask;
    logic [NSW-1:0] switches;
    logic [NBT-1:0] pushButtons;
    logic [NBT-1:0] press_events;
    logic           event_any;

    io_input_conditioner #(
        .NUM_SW         (NSW),
        .NUM_BTN        (NBT),
        .DEBOUNCE_CYCLES(DC),
        .BTN_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .switches_raw  (switches_raw),
        .buttons_raw   (buttons_raw),
        .evt_clear     (evt_clear),
        .evt_clear_mask(evt_clear_mask),
        .switches      (switches),
        .pushButtons   (pushButtons),
        .press_events  (press_events),
        .event_any     (event_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NSW-1:0] sw;
        logic [NBT-1:0] btn;
        logic [NBT-1:0] ev;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a debounced bit takes value v once the last DC synchronized
    // samples (raw samples two edges old) are all v; otherwise it holds.
    logic [NSW-1:0] sw_hist[$];
    logic [NBT-1:0] bt_hist[$];
    logic [NSW-1:0] m_sw;
    logic [NBT-1:0] m_btn;
    logic [NBT-1:0] m_ev;

    function automatic void model_reset();
        sw_hist.delete();
        bt_hist.delete();
        for (int i = 0; i < DC + 2; i++) begin
            sw_hist.push_back('0);
            bt_hist.push_back('0);
        end
        m_sw  = '0;
        m_btn = '0;
        m_ev  = '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    logic [NSW-1:0] cur_sw;
    logic [NBT-1:0] cur_btn;

    task automatic step(input logic clr, input logic [NBT-1:0] mask, input logic rst);
        exp_t           e;
        logic [NSW-1:0] all1_sw, all0_sw;
        logic [NBT-1:0] all1_bt, all0_bt, prev;
        @(negedge clk);
        switches_raw   = cur_sw;
        buttons_raw    = cur_btn;
        evt_clear      = clr;
        evt_clear_mask = mask;
        reset          = rst;
        if (rst) begin
            model_reset();
            #1;
            chk("reset_switches", 32'(switches), 32'd0);
            chk("reset_events", {26'd0, press_events, event_any}, 32'd0);
        end else begin
            sw_hist.push_back(cur_sw);
            void'(sw_hist.pop_front());
            bt_hist.push_back(~cur_btn);
            void'(bt_hist.pop_front());
            all1_sw = '1; all0_sw = '1;
            all1_bt = '1; all0_bt = '1;
            for (int i = 0; i < DC; i++) begin
                all1_sw &= sw_hist[i];
                all0_sw &= ~sw_hist[i];
                all1_bt &= bt_hist[i];
                all0_bt &= ~bt_hist[i];
            end
            prev  = m_btn;
            m_sw  = (m_sw | all1_sw) & ~all0_sw;
            m_btn = (m_btn | all1_bt) & ~all0_bt;
            m_ev  = (m_ev & ~(clr ? mask : '0)) | (m_btn & ~prev);
        end
        e.sw  = m_sw;
        e.btn = m_btn;
        e.ev  = m_ev;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("switches", 32'(switches), 32'(e.sw));
                chk("pushButtons", 32'(pushButtons), 32'(e.btn));
                chk("press_events", 32'(press_events), 32'(e.ev));
                chk("event_any", 32'(event_any), 32'(|e.ev));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int seg;
        reset          = 1'b1;
        switches_raw   = '0;
        buttons_raw    = '1;
        evt_clear      = 1'b0;
        evt_clear_mask = '0;
        cur_sw         = '0;
        cur_btn        = '1;
        model_reset();

        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        idle(3);

        // switch 3 held high: output at the 10th sampling edge
        cur_sw[3] = 1'b1;
        idle(12);

        // 5-cycle glitch on button 0 must be filtered
        cur_btn[0] = 1'b0;
        idle(5);
        cur_btn[0] = 1'b1;
        idle(12);

        // button 2 held 20 cycles, then released; flag stays
        cur_btn[2] = 1'b0;
        idle(20);
        cur_btn[2] = 1'b1;
        idle(12);

        // empty-mask clear does nothing, then clear bit 2
        step(1'b1, 5'b00000, 1'b0);
        step(1'b1, 5'b00100, 1'b0);
        idle(2);

        // clear coinciding with the debounced press: set wins
        cur_btn[2] = 1'b0;
        for (int i = 1; i <= 10; i++) step(i == 10, 5'b00100, 1'b0);
        step(1'b1, 5'b00100, 1'b0);
        cur_btn[2] = 1'b1;
        idle(12);

        // reset mid-count abandons the pending change
        cur_sw[5] = 1'b1;
        idle(7);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(12);

        // two buttons bouncing alternately, then both held
        for (int i = 0; i < 30; i++) begin
            cur_btn[3] = ((i / 3) % 2) != 0;
            cur_btn[4] = ((i / 3) % 2) == 0;
            step(1'b0, '0, 1'b0);
        end
        cur_btn[3] = 1'b0;
        cur_btn[4] = 1'b0;
        idle(15);
        cur_btn = '1;
        idle(12);
        step(1'b1, '1, 1'b0);

        // randomized segments
        for (int s = 0; s < 60; s++) begin
            cur_sw  = NSW'($urandom);
            cur_btn = NBT'($urandom);
            seg = $urandom_range(1, 14);
            for (int i = 0; i < seg; i++) begin
                if ($urandom_range(0, 99) == 0) step(1'b0, '0, 1'b1);
                else step($urandom_range(0, 3) == 0, NBT'($urandom), 1'b0);
            end
        end
        cur_btn = '1;
        idle(12);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
